// File: rtl/draw_scheduler_pkg.sv
// Shared widths and scheduler state encoding for the draw scheduler slice.
package draw_pkg;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/draw_scheduler_if.sv
// Engine-side request/pixel bundle and adapter-side write port of the draw scheduler.
interface draw_scheduler_if #(
  parameter int N_ENG = 4,
  parameter int ID_W  = 2
);
  import draw_pkg::*;

  logic [N_ENG-1:0]       req;
  logic [N_ENG*X_W-1:0]   eng_x;
  logic [N_ENG*Y_W-1:0]   eng_y;
  logic [N_ENG*COL_W-1:0] eng_col;
  logic [N_ENG-1:0]       eng_plot;
  logic [N_ENG-1:0]       eng_done;
  logic [N_ENG-1:0]       eng_enable;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [COL_W-1:0]       vga_col;
  logic                   vga_plot;
  logic                   busy;
  logic [ID_W-1:0]        active_id;
  logic                   grant_done;
  logic                   timeout_err;

  modport master (
    output req, eng_x, eng_y, eng_col, eng_plot, eng_done,
    input  eng_enable, vga_x, vga_y, vga_col, vga_plot,
           busy, active_id, grant_done, timeout_err
  );

  modport slave (
    input  req, eng_x, eng_y, eng_col, eng_plot, eng_done,
    output eng_enable, vga_x, vga_y, vga_col, vga_plot,
           busy, active_id, grant_done, timeout_err
  );
endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_id, wrapping modulo N_ENG.
module rr_arbiter #(
  parameter int N_ENG = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_ENG-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             valid,
  output logic [ID_W-1:0]  grant_id
);
  int unsigned j;

  always_comb begin
    valid    = 1'b0;
    grant_id = '0;
    j        = 0;
    for (int unsigned k = 1; k <= N_ENG; k++) begin
      j = (32'(last_id) + k) % N_ENG;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant_id = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/draw_scheduler.sv
// Round-robin draw scheduler: grants one engine and forwards its pixels to the VGA port.
// Optional forced release per grant when DRAW_TIMEOUT_EN is defined.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int N_ENG          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int TO_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  draw_scheduler_if.slave  bus
);
  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [N_ENG-1:0]   en_q, en_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COL_W-1:0]   vga_col_q, vga_col_d;
  logic               vga_plot_q, vga_plot_d;
  logic               grant_done_q, grant_done_d;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_id;
  logic               done_act, req_act, timeout_hit, release_act;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TO_W)) begin : g_cfg_err
    $error("draw_scheduler: TIMEOUT_CYCLES must be >= 2 and fit in TO_W bits");
  end

  rr_arbiter #(.N_ENG(N_ENG), .ID_W(ID_W)) u_arb (
    .req      (bus.req),
    .last_id  (last_id_q),
    .valid    (arb_valid),
    .grant_id (arb_id)
  );

  assign done_act    = bus.eng_done[active_id_q];
  assign req_act     = bus.req[active_id_q];
  assign release_act = done_act || !req_act || timeout_hit;

`ifdef DRAW_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  assign timeout_hit = (state_q == ACTIVE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d    = (state_q == ACTIVE) ? to_cnt_q + 1'b1 : '0;
  assign to_err_d    = to_err_q || (timeout_hit && !done_act);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    active_id_d  = active_id_q;
    last_id_d    = last_id_q;
    en_d         = en_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_col_d    = vga_col_q;
    vga_plot_d   = 1'b0;
    grant_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          active_id_d = arb_id;
          en_d        = N_ENG'(1) << arb_id;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        vga_x_d   = bus.eng_x[active_id_q*X_W +: X_W];
        vga_y_d   = bus.eng_y[active_id_q*Y_W +: Y_W];
        vga_col_d = bus.eng_col[active_id_q*COL_W +: COL_W];
        // Releasing cycle suppresses the write so DRAIN never plots.
        if (release_act) begin
          en_d         = '0;
          grant_done_d = 1'b1;
          state_d      = DRAIN;
        end else begin
          vga_plot_d = bus.eng_plot[active_id_q];
        end
      end
      DRAIN: begin
        last_id_d = active_id_q;
        state_d   = IDLE;
      end
      default: begin
        en_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      active_id_q  <= '0;
      last_id_q    <= ID_W'(N_ENG - 1);
      en_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_col_q    <= '0;
      vga_plot_q   <= 1'b0;
      grant_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_id_q  <= active_id_d;
      last_id_q    <= last_id_d;
      en_q         <= en_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_col_q    <= vga_col_d;
      vga_plot_q   <= vga_plot_d;
      grant_done_q <= grant_done_d;
    end
  end

  assign bus.eng_enable = en_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_col    = vga_col_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.busy       = (state_q == ACTIVE) || (state_q == DRAIN);
  assign bus.active_id  = active_id_q;
  assign bus.grant_done = grant_done_q;
endmodule
